ws2812_multi_driver: RTL and testbench
======================================

WS2812_MULTI_DRIVER -- requirements
Module: ws2812_multi_driver

Interface
REQ-001 SHALL have parameter NUM_STRIPS, default 4: number of parallel LED strip outputs.
REQ-002 SHALL have parameter NUM_LEDS, default 160: LEDs per strip.
REQ-003 SHALL have parameter NUM_CHANNELS, default 3: bytes per LED.
REQ-004 SHALL have parameter ADDR_WIDTH, default 13: memory address width, at least clog2(NUM_STRIPS*NUM_LEDS*NUM_CHANNELS).
REQ-005 SHALL have parameters T_TOTAL=70, T0H=20, T1H=50, T_RESET=50000: clk cycles for bit period, 0-high, 1-high and latch gap.
REQ-006 SHALL have parameter MEM_LATENCY, default 2: cycles from mem_addr to valid mem_dout.
REQ-007 clk  in  1  sole clock, rising edge.
REQ-008 rst  in  1  reset, asynchronous, active-high.
REQ-009 start  in  1  one-cycle request for one frame; honoured only in IDLE.
REQ-010 continuous  in  1  when high at end of LATCH, next frame starts without start.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 frame_done  out  1  one-cycle pulse on the last LATCH cycle.
REQ-013 mem_addr  out  ADDR_WIDTH  read address to frame-buffer BRAM.
REQ-014 mem_dout  in  8  read data, valid MEM_LATENCY cycles after mem_addr.
REQ-015 strip_do  out  NUM_STRIPS  serial data per strip; bit s drives strip s.

Function
REQ-016 States: IDLE, LOAD, DRIVE, LATCH; IDLE->LOAD on start; LOAD->DRIVE when all strips' byte 0 captured; DRIVE->LATCH after last bit of byte NUM_LEDS*NUM_CHANNELS-1; LATCH->DRIVE if continuous, else IDLE, after T_RESET cycles.
REQ-017 Byte b of strip s SHALL be read from address s*NUM_LEDS*NUM_CHANNELS + b.
REQ-018 Each lane SHALL hold a shift register and a shadow register; at each byte boundary shadow copies into shift in the same cycle the next bit period starts.
REQ-019 Shadow fill for byte b+1 SHALL complete during byte b (issue NUM_STRIPS reads, one per cycle, starting at bit period 0 count 0); parameters SHALL satisfy NUM_STRIPS+MEM_LATENCY < 8*T_TOTAL and < T_RESET.
REQ-020 LOAD SHALL last exactly NUM_STRIPS+MEM_LATENCY cycles; LATCH SHALL prefetch byte 0 so DRIVE restarts with no gap.
REQ-021 Bits SHALL be sent MSB first, all strips in lockstep, T_TOTAL cycles per bit.
REQ-022 Within a bit period with count c in 0..T_TOTAL-1, strip_do[s] SHALL be high when c < T0H for a 0 and c < T1H for a 1, else low.
REQ-023 strip_do SHALL be all-low in IDLE, LOAD and LATCH; outputs registered, no combinational path from inputs.
REQ-024 start in any state other than IDLE SHALL be ignored; continuous dropped mid-frame SHALL let the frame and LATCH finish, then go IDLE.
REQ-025 Byte and bit counters SHALL wrap to 0 at frame end; no address SHALL exceed NUM_STRIPS*NUM_LEDS*NUM_CHANNELS-1.

Reset
REQ-026 rst SHALL force immediately: state IDLE, strip_do=0, busy=0, frame_done=0, mem_addr=0, all counters and lane registers 0.
REQ-027 rst asserted mid-frame SHALL abort the frame with no frame_done; the first frame after release SHALL need start.

Structure
REQ-028 Package ws2812_pkg SHALL hold the state enum and default timing constants (T_TOTAL, T0H, T1H, T_RESET).
REQ-029 One sub-module ws2812_lane (shadow load, shift, bit encoding against shared count) SHALL be instantiated NUM_STRIPS times.

Verification (NUM_STRIPS=2, NUM_LEDS=2, NUM_CHANNELS=3, T_TOTAL=10, T0H=3, T1H=7, T_RESET=40, MEM_LATENCY=2)
REQ-030 Memory 0x80,0,0,0,0,0 | 0,0,0,0,0,0x01; one start -> strip 0 first bit high 7 cycles, 47 other bits high 3; strip 1 last bit high 7; one frame_done; back to IDLE.
REQ-031 Continuous=1, two frames -> LATCH exactly 40 low cycles between frames, frame_done twice, DRIVE restarts with no extra gap.
REQ-032 start pulsed during DRIVE -> no effect; frame length exactly 4+480+40 cycles from start.
REQ-033 rst asserted at byte 3 bit 5 -> strip_do and busy low same cycle; no frame_done; start after release sends full frame from byte 0.
REQ-034 Check mem_addr sequence: 0,6 in LOAD; 1,7 in byte 0; never exceeds 11.
REQ-035 Continuous dropped mid-frame -> frame completes, one frame_done, IDLE, busy low.

Source files
------------

// File: rtl/ws2812_pkg.sv
// Shared FSM encoding and default WS2812 timing, in clk cycles (50 MHz gives a 1.4 us bit period and a 1 ms latch gap).
package ws2812_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, DRIVE, LATCH} state_t;

    localparam int T_TOTAL = 70;
    localparam int T0H     = 20;
    localparam int T1H     = 50;
    localparam int T_RESET = 50000;
endpackage

// File: rtl/ws2812_lane.sv
// One strip lane: shadow byte, MSB-first shift register and registered NRZ pulse encoder.
module ws2812_lane #(
    parameter int CW  = 7,
    parameter int T0H = ws2812_pkg::T0H,
    parameter int T1H = ws2812_pkg::T1H
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cap,
    input  logic [7:0]    din,
    input  logic          load,
    input  logic          shift_en,
    input  logic          drive_nxt,
    input  logic [CW-1:0] cnt_nxt,
    output logic          sd
);
    import ws2812_pkg::*;

    localparam logic [CW-1:0] H0 = CW'(T0H);
    localparam logic [CW-1:0] H1 = CW'(T1H);

    logic [7:0] shadow;
    logic [7:0] shift;
    logic [7:0] shift_nxt;

    // A capture landing on the same edge as the reload bypasses the shadow.
    always_comb begin
        shift_nxt = shift;
        if (load)
            shift_nxt = cap ? din : shadow;
        else if (shift_en)
            shift_nxt = {shift[6:0], 1'b0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
            shift  <= '0;
            sd     <= 1'b0;
        end else begin
            if (cap)
                shadow <= din;
            shift <= shift_nxt;
            sd    <= drive_nxt && (cnt_nxt < (shift_nxt[7] ? H1 : H0));
        end
    end
endmodule

// File: rtl/ws2812_multi_driver.sv
// Drives NUM_STRIPS WS2812 strips in lockstep from one frame-buffer BRAM, prefetching each lane's next byte.
module ws2812_multi_driver #(
    parameter int NUM_STRIPS   = 4,
    parameter int NUM_LEDS     = 160,
    parameter int NUM_CHANNELS = 3,
    parameter int ADDR_WIDTH   = 13,
    parameter int T_TOTAL      = ws2812_pkg::T_TOTAL,
    parameter int T0H          = ws2812_pkg::T0H,
    parameter int T1H          = ws2812_pkg::T1H,
    parameter int T_RESET      = ws2812_pkg::T_RESET,
    parameter int MEM_LATENCY  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  continuous,
    output logic                  busy,
    output logic                  frame_done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [7:0]            mem_dout,
    output logic [NUM_STRIPS-1:0] strip_do
);
    import ws2812_pkg::*;

    localparam int NB = NUM_LEDS * NUM_CHANNELS;
    localparam int F  = NUM_STRIPS + MEM_LATENCY;
    localparam int CW = $clog2(T_TOTAL);
    localparam int LW = $clog2(T_RESET);
    localparam int BW = $clog2(NB + 1);
    localparam int FW = $clog2(F + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(T_TOTAL - 1);
    localparam logic [LW-1:0] LAT_LAST  = LW'(T_RESET - 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(NB - 1);
    localparam logic [BW-1:0] BYTE_PEN  = BW'(NB - 2);
    localparam logic [FW-1:0] F_LAST    = FW'(F - 1);
    localparam logic [FW-1:0] F_DONE    = FW'(F);

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [2:0]      bit_idx, bit_nxt;
    logic [BW-1:0]   byte_idx, byte_nxt;
    logic [LW-1:0]   lat_cnt, lat_nxt;
    logic [FW-1:0]   fcnt, fcnt_nxt;
    logic [BW-1:0]   fbyte, fbyte_nxt;
    logic            load_shift, shift_en;
    logic [FW-1:0]   cap_idx;
    logic            cap_on;
    logic [ADDR_WIDTH-1:0] addr_nxt;

    // fcnt walks a fetch window: reads issue at 0..NUM_STRIPS-1, data lands MEM_LATENCY later.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        bit_nxt    = bit_idx;
        byte_nxt   = byte_idx;
        lat_nxt    = lat_cnt;
        fbyte_nxt  = fbyte;
        fcnt_nxt   = (state == IDLE || fcnt == F_DONE) ? fcnt : fcnt + FW'(1);
        load_shift = 1'b0;
        shift_en   = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_nxt = LOAD;
                fcnt_nxt  = '0;
                fbyte_nxt = '0;
                cnt_nxt   = '0;
                bit_nxt   = '0;
                byte_nxt  = '0;
            end
            LOAD: if (fcnt == F_LAST) begin
                state_nxt  = DRIVE;
                load_shift = 1'b1;
                if (NB > 1) begin
                    fcnt_nxt  = '0;
                    fbyte_nxt = BW'(1);
                end
            end
            DRIVE: begin
                cnt_nxt = cnt + CW'(1);
                if (cnt == CNT_LAST) begin
                    cnt_nxt = '0;
                    if (bit_idx == 3'd7) begin
                        bit_nxt = '0;
                        if (byte_idx == BYTE_LAST) begin
                            state_nxt = LATCH;
                            byte_nxt  = '0;
                            lat_nxt   = '0;
                            fcnt_nxt  = '0;
                            fbyte_nxt = '0;
                        end else begin
                            byte_nxt   = byte_idx + BW'(1);
                            load_shift = 1'b1;
                            if (byte_idx != BYTE_PEN) begin
                                fcnt_nxt  = '0;
                                fbyte_nxt = byte_idx + BW'(2);
                            end
                        end
                    end else begin
                        bit_nxt  = bit_idx + 3'd1;
                        shift_en = 1'b1;
                    end
                end
            end
            LATCH: begin
                lat_nxt = lat_cnt + LW'(1);
                if (lat_cnt == LAT_LAST) begin
                    lat_nxt = '0;
                    if (continuous) begin
                        state_nxt  = DRIVE;
                        load_shift = 1'b1;
                        if (NB > 1) begin
                            fcnt_nxt  = '0;
                            fbyte_nxt = BW'(1);
                        end
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign addr_nxt = ADDR_WIDTH'(fcnt_nxt) * ADDR_WIDTH'(NB) + ADDR_WIDTH'(fbyte_nxt);
    // Early fcnt values wrap above NUM_STRIPS, so one compare covers both window ends.
    assign cap_idx  = fcnt - FW'(MEM_LATENCY);
    assign cap_on   = (state != IDLE) && (cap_idx < FW'(NUM_STRIPS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            byte_idx   <= '0;
            lat_cnt    <= '0;
            fcnt       <= '0;
            fbyte      <= '0;
            mem_addr   <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bit_idx    <= bit_nxt;
            byte_idx   <= byte_nxt;
            lat_cnt    <= lat_nxt;
            fcnt       <= fcnt_nxt;
            fbyte      <= fbyte_nxt;
            busy       <= (state_nxt != IDLE);
            frame_done <= (state_nxt == LATCH) && (lat_nxt == LAT_LAST);
            if (state_nxt != IDLE && fcnt_nxt < FW'(NUM_STRIPS))
                mem_addr <= addr_nxt;
        end
    end

    for (genvar s = 0; s < NUM_STRIPS; s++) begin : g_lane
        ws2812_lane #(.CW(CW), .T0H(T0H), .T1H(T1H)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .cap       (cap_on && cap_idx == FW'(s)),
            .din       (mem_dout),
            .load      (load_shift),
            .shift_en  (shift_en),
            .drive_nxt (state_nxt == DRIVE),
            .cnt_nxt   (cnt_nxt),
            .sd        (strip_do[s])
        );
    end
endmodule

// File: tb/tb_ws2812_multi_driver.sv
// Directed bench: 2 strips x 6 bytes, 10-cycle bits, 40-cycle latch, 2-cycle BRAM model.
module tb_ws2812_multi_driver;
    localparam int FRAME = 4 + 48 * 10 + 40;

    logic       clk = 1'b0;
    logic       rst, start, continuous, busy, frame_done;
    logic [3:0] mem_addr;
    logic [7:0] mem_dout, p1;
    logic [1:0] strip_do;
    logic [7:0] mem [12];

    typedef struct {
        int img;
        int strip;
        int bitn;
        int hi;
    } vec_t;
    vec_t tbl[22];

    int vecs = 0, miss = 0;
    int cyc = 0, busy_cyc, fd_cnt, fd_t, b0, max_addr, run0, run1;
    logic pv0, pv1;
    int hl0[$], hl1[$], rt0[$], addr_q[$];

    ws2812_multi_driver #(
        .NUM_STRIPS(2), .NUM_LEDS(2), .NUM_CHANNELS(3), .ADDR_WIDTH(4),
        .T_TOTAL(10), .T0H(3), .T1H(7), .T_RESET(40), .MEM_LATENCY(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous),
        .busy(busy), .frame_done(frame_done), .mem_addr(mem_addr),
        .mem_dout(mem_dout), .strip_do(strip_do)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        p1       <= (mem_addr < 4'd12) ? mem[mem_addr] : 8'hEE;
        mem_dout <= p1;
    end

    always @(negedge clk) begin
        cyc++;
        if (busy) begin
            busy_cyc++;
            if (b0 < 0) b0 = cyc;
            if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
            if (addr_q.size() < 8) addr_q.push_back(int'(mem_addr));
        end
        if (frame_done) begin
            fd_cnt++;
            fd_t = cyc;
        end
        if (strip_do[0]) begin
            if (!pv0) rt0.push_back(cyc);
            run0++;
        end else if (pv0) begin
            hl0.push_back(run0);
            run0 = 0;
        end
        if (strip_do[1]) run1++;
        else if (pv1) begin
            hl1.push_back(run1);
            run1 = 0;
        end
        pv0 = strip_do[0];
        pv1 = strip_do[1];
    end

    task automatic chk(input string name, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clr();
        busy_cyc = 0; fd_cnt = 0; fd_t = 0; b0 = -1; max_addr = 0;
        run0 = 0; run1 = 0; pv0 = 1'b0; pv1 = 1'b0;
        hl0.delete(); hl1.delete(); rt0.delete(); addr_q.delete();
    endtask

    task automatic load_img(input int img);
        for (int i = 0; i < 12; i++) mem[i] = 8'h00;
        if (img == 0) begin
            mem[0] = 8'h80; mem[11] = 8'h01;
        end else begin
            mem[0] = 8'hA5; mem[5] = 8'hFF; mem[8] = 8'h0F;
        end
    endtask

    task automatic pulse();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("reach_idle", int'(busy), 0);
    endtask

    // Independent reference: a 1 bit is 7 cycles high, a 0 bit 3, MSB first, byte b of strip s at s*6+b.
    function automatic int bits_bad(input int nf);
        int bad = 0;
        int e0, e1;
        if (hl0.size() < 48 * nf || hl1.size() < 48 * nf) return 999;
        for (int f = 0; f < nf; f++)
            for (int k = 0; k < 48; k++) begin
                e0 = mem[k / 8][7 - k % 8] ? 7 : 3;
                e1 = mem[6 + k / 8][7 - k % 8] ? 7 : 3;
                if (hl0[f * 48 + k] != e0) bad++;
                if (hl1[f * 48 + k] != e1) bad++;
            end
        return bad;
    endfunction

    function automatic int period_bad();
        int bad = 0;
        for (int i = 0; i + 1 < rt0.size(); i++)
            if ((i + 1) % 48 != 0 && rt0[i + 1] - rt0[i] != 10) bad++;
        return bad;
    endfunction

    initial begin
        tbl = '{
            '{0, 0, 0, 7}, '{0, 0, 1, 3}, '{0, 0, 7, 3}, '{0, 0, 8, 3},
            '{0, 0, 47, 3}, '{0, 1, 0, 3}, '{0, 1, 40, 3}, '{0, 1, 47, 7},
            '{1, 0, 0, 7}, '{1, 0, 1, 3}, '{1, 0, 2, 7}, '{1, 0, 5, 7},
            '{1, 0, 6, 3}, '{1, 0, 7, 7}, '{1, 0, 39, 3}, '{1, 0, 40, 7},
            '{1, 1, 15, 3}, '{1, 1, 16, 3}, '{1, 1, 19, 3}, '{1, 1, 20, 7},
            '{1, 1, 23, 7}, '{1, 1, 24, 3}
        };
        rst = 1'b1; start = 1'b0; continuous = 1'b0;
        clr();
        load_img(0);
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_strip_do", int'(strip_do), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        @(negedge clk) rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("idle_no_start", busy_cyc, 0);

        // Single frames from the table images
        for (int img = 0; img < 2; img++) begin
            load_img(img);
            clr();
            pulse();
            wait_idle();
            chk($sformatf("img%0d_busy_cycles", img), busy_cyc, FRAME);
            chk($sformatf("img%0d_frame_done", img), fd_cnt, 1);
            chk($sformatf("img%0d_fd_last_latch", img), fd_t - b0, FRAME - 1);
            chk($sformatf("img%0d_bits0", img), hl0.size(), 48);
            chk($sformatf("img%0d_bits1", img), hl1.size(), 48);
            chk($sformatf("img%0d_bits_bad", img), bits_bad(1), 0);
            chk($sformatf("img%0d_period_bad", img), period_bad(), 0);
            chk($sformatf("img%0d_addr_max", img), int'(max_addr <= 11), 1);
            chk($sformatf("img%0d_first_rise", img), (rt0.size() > 0) ? rt0[0] - b0 : -1, 4);
            foreach (tbl[i])
                if (tbl[i].img == img)
                    chk($sformatf("img%0d_s%0d_b%0d", img, tbl[i].strip, tbl[i].bitn),
                        (tbl[i].strip == 0) ? ((hl0.size() > tbl[i].bitn) ? hl0[tbl[i].bitn] : -1)
                                            : ((hl1.size() > tbl[i].bitn) ? hl1[tbl[i].bitn] : -1),
                        tbl[i].hi);
            if (img == 0) begin
                chk("addr_load0", (addr_q.size() > 5) ? addr_q[0] : -1, 0);
                chk("addr_load1", (addr_q.size() > 5) ? addr_q[1] : -1, 6);
                chk("addr_byte0_0", (addr_q.size() > 5) ? addr_q[4] : -1, 1);
                chk("addr_byte0_1", (addr_q.size() > 5) ? addr_q[5] : -1, 7);
            end
        end

        // Two continuous frames, continuous dropped during the second
        load_img(0);
        clr();
        continuous = 1'b1;
        pulse();
        for (int i = 0; i < 1000 && fd_cnt < 1; i++) @(negedge clk);
        chk("cont_fd1_seen", fd_cnt, 1);
        repeat (100) @(negedge clk);
        continuous = 1'b0;
        wait_idle();
        chk("cont_frame_done", fd_cnt, 2);
        chk("cont_busy_cycles", busy_cyc, 2 * FRAME - 4);
        chk("cont_rises", rt0.size(), 96);
        chk("cont_latch_gap", (rt0.size() > 48) ? rt0[48] - rt0[47] : -1, 50);
        chk("cont_f2_bit0", (hl0.size() > 48) ? hl0[48] : -1, 7);
        chk("cont_bits_bad", bits_bad(2), 0);
        chk("cont_period_bad", period_bad(), 0);

        // continuous dropped mid-frame in the first frame
        clr();
        continuous = 1'b1;
        pulse();
        repeat (200) @(negedge clk);
        continuous = 1'b0;
        wait_idle();
        chk("drop_frame_done", fd_cnt, 1);
        chk("drop_busy_cycles", busy_cyc, FRAME);

        // start pulses during DRIVE are ignored
        clr();
        pulse();
        repeat (100) @(negedge clk);
        pulse();
        repeat (250) @(negedge clk);
        pulse();
        wait_idle();
        chk("restart_busy_cycles", busy_cyc, FRAME);
        chk("restart_frame_done", fd_cnt, 1);
        repeat (30) @(negedge clk);
        chk("restart_stays_idle", busy_cyc, FRAME);

        // reset at byte 3 bit 5 count 2
        load_img(1);
        clr();
        pulse();
        repeat (296) @(posedge clk);
        #2;
        chk("pre_rst_strip_do", int'(strip_do), 3);
        chk("pre_rst_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_strip_do", int'(strip_do), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_mem_addr", int'(mem_addr), 0);
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (50) @(negedge clk);
        chk("post_rst_no_fd", fd_cnt, 0);
        chk("post_rst_idle", int'(busy), 0);
        clr();
        pulse();
        wait_idle();
        chk("post_rst_busy_cycles", busy_cyc, FRAME);
        chk("post_rst_frame_done", fd_cnt, 1);
        chk("post_rst_bits_bad", bits_bad(1), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
